// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus
// for serial_adder. With ADD_SUB_EN defined, the bus also carries the
// per-operation add/subtract select "sub".
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

`ifdef ADD_SUB_EN
  // Requester side: issues operations, observes status and results.
  modport master (
    output start, a, b, sub,
    input  busy, done, s, c, ovf
  );

  // Adder side: accepts operations, returns status and results.
  modport slave (
    input  start, a, b, sub,
    output busy, done, s, c, ovf
  );
`else
  // Requester side: issues operations, observes status and results.
  modport master (
    output start, a, b,
    input  busy, done, s, c, ovf
  );

  // Adder side: accepts operations, returns status and results.
  modport slave (
    input  start, a, b,
    output busy, done, s, c, ovf
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// An accepted request takes WIDTH+1 edges (accept, then WIDTH bit steps);
// results land in output registers that hold until the next completion.
// Optional feature macro: ADD_SUB_EN adds the "sub" input. When sub=1 the
// adder computes A + ~B + 1 (A-B); c=1 then means no borrow.
// Legal WIDTH range is 2..64.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  // Counter needs to reach WIDTH-1 without wrapping for every legal WIDTH.
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             load;
  logic             step;
  logic             last;
  logic             sub_sel;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             cy;
  logic             cy_nxt;
  logic             bit_sum;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;

  // Carry out of a full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Sum bit of a full-adder cell.
  function automatic logic xor3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

`ifdef ADD_SUB_EN
  // Subtract select is only looked at on the accepting edge, so toggling it
  // while running cannot disturb the operation in flight.
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  // One full-adder cell shared across all bit positions.
  assign bit_sum = xor3(a_sr[0], b_sr[0], cy);
  assign cy_nxt  = maj3(a_sr[0], b_sr[0], cy);
  assign sum_nxt = {bit_sum, sum_sr[WIDTH-1:1]};

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here: operands are never re-sampled.
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers, partial sum, carry flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= sub_sel ? ~bus.b : bus.b;
      sum_sr <= '0;
      cy     <= sub_sel;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nxt;
      cy     <= cy_nxt;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers: written only on the final bit, so they hold the
  // previous result while the next operation runs. The carry flop still
  // holds the carry into the MSB during the final step, which gives ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (last) begin
      s_q   <= sum_nxt;
      c_q   <= cy_nxt;
      ovf_q <= cy ^ cy_nxt;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.c    = c_q;
  assign bus.ovf  = ovf_q;

endmodule
